// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch debounce stage.
package sw_pkg;

  localparam int SW_W              = 10;
  localparam int SW_STABLE_DEFAULT = 1000000;
  localparam int SW_STABLE_SIM     = 4;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bundle: raw switch levels in, debounced levels and strobes out.
// sw_chg/sw_rise/sw_fall are single-cycle strobes with no back-pressure (no ready).
interface sw_debounce_if
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_W
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_chg;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_chg,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_chg,
    output sw_rise,
    output sw_fall
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced flop and update strobes.
// Edge pulses exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic chg,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             upd;

  // The new level is adopted on the edge where the count has already reached LAST.
  assign upd = (s2 != db) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
      chg <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      chg <= upd;
      if (s2 == db) begin
        cnt <= '0;
      end else if (upd) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd & s2;
      fall <= upd & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches; sw_chg pulses when any debounced bit updates.
// Optional per-bit rise/fall pulses are enabled by SW_DEBOUNCE_EDGE_EN.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = SW_W,
  parameter int STABLE_CYCLES = SW_STABLE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] chg_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.sw_raw[i]),
      .db   (bus.sw_db[i]),
      .chg  (chg_v[i]),
      .rise (bus.sw_rise[i]),
      .fall (bus.sw_fall[i])
    );
  end

  // Per-bit strobes are registered, so the OR is one pulse per update edge.
  assign bus.sw_chg = |chg_v;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES = SW_STABLE_SIM.
// Expected updates are queued at stimulus time and checked by an independent monitor.
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int W     = SW_W;
  localparam int STAB  = SW_STABLE_SIM;
  localparam int EXP_W = 32 + 3 * W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [W-1:0]     mdl_db;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (STAB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (inputs change only at negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expect(input logic [W-1:0] new_db);
    logic [W-1:0] r;
    logic [W-1:0] f;
    int           at;
`ifdef SW_DEBOUNCE_EDGE_EN
    r = new_db & ~mdl_db;
    f = ~new_db & mdl_db;
`else
    r = '0;
    f = '0;
`endif
    at = cyc + STAB + 2;
    exp_q.push_back({at[31:0], new_db, r, f});
    mdl_db = new_db;
  endtask

  task automatic drive_raw(input logic [W-1:0] v);
    @(negedge clk);
    bus.sw_raw = v;
  endtask

  task automatic apply_clean(input logic [W-1:0] v);
    @(negedge clk);
    bus.sw_raw = v;
    push_expect(v);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0]     cur_db;
    logic [EXP_W-1:0] e;
    int               e_cyc;
    cur_db = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        total++;
        if (bus.sw_db !== '0 || bus.sw_chg !== 1'b0 || bus.sw_rise !== '0 || bus.sw_fall !== '0) begin
          bad++;
          $display("FAIL reset_outputs cyc=%0d got db=%h chg=%b rise=%h fall=%h want all 0",
                   cyc, bus.sw_db, bus.sw_chg, bus.sw_rise, bus.sw_fall);
        end
        cur_db = '0;
      end else if (bus.sw_chg === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_chg cyc=%0d got db=%h want no update", cyc, bus.sw_db);
        end else begin
          e     = exp_q.pop_front();
          e_cyc = int'(e[EXP_W-1 -: 32]);
          if (e_cyc != cyc || bus.sw_db !== e[3*W-1 -: W] ||
              bus.sw_rise !== e[2*W-1 -: W] || bus.sw_fall !== e[W-1:0]) begin
            bad++;
            $display("FAIL update cyc=%0d db=%h rise=%h fall=%h want cyc=%0d db=%h rise=%h fall=%h",
                     cyc, bus.sw_db, bus.sw_rise, bus.sw_fall,
                     e_cyc, e[3*W-1 -: W], e[2*W-1 -: W], e[W-1:0]);
          end
          cur_db = e[3*W-1 -: W];
        end
      end else begin
        total++;
        if (bus.sw_chg !== 1'b0 || bus.sw_db !== cur_db || bus.sw_rise !== '0 || bus.sw_fall !== '0) begin
          bad++;
          $display("FAIL hold cyc=%0d got db=%h chg=%b rise=%h fall=%h want db=%h chg=0 rise=0 fall=0",
                   cyc, bus.sw_db, bus.sw_chg, bus.sw_rise, bus.sw_fall, cur_db);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    bus.sw_raw = 10'h3FF;
    mdl_db     = '0;

    // Reset with all switches on; release and expect all bits on the 6th edge.
    idle(3);
    rst = 1'b0;
    push_expect(10'h3FF);
    idle(10);

    // Clear everything, then clean rise on bit 2.
    apply_clean(10'h000);
    idle(10);
    apply_clean(10'h004);
    idle(10);

    // Bounce on bit 5: 1,0,1,0 each held 2 cycles, then a stable 1.
    drive_raw(10'h024); idle(1);
    drive_raw(10'h004); idle(1);
    drive_raw(10'h024); idle(1);
    drive_raw(10'h004); idle(1);
    apply_clean(10'h024);
    idle(10);

    // Short glitch on bit 0: 3 cycles high, never adopted.
    drive_raw(10'h025); idle(2);
    drive_raw(10'h024);
    idle(10);

    // Simultaneous multi-bit update from all-zero.
    apply_clean(10'h000);
    idle(10);
    apply_clean(10'h2A5);
    idle(10);
    apply_clean(10'h000);
    idle(10);

    // Bit 9 rises; reset lands when its count has reached 2.
    drive_raw(10'h200);
    idle(4);
    rst    = 1'b1;
    mdl_db = '0;
    @(negedge clk);
    rst = 1'b0;
    push_expect(10'h200);
    idle(12);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_updates got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
